// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel word as start bit, data bits
// LSB-first, optional parity and stop bit(s), stepped by an external baud tick.
// The baud generator is enabled only while a frame is in flight.
module uart_tx_serializer #(
   parameter int unsigned DATA_BITS = 8,  // 5..8
   parameter int unsigned PARITY    = 0,  // 0 none, 1 even, 2 odd, 3 none
   parameter int unsigned STOP_BITS = 1   // 1 or 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 baud_en,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam bit         HasParity = (PARITY == 1) || (PARITY == 2);
   localparam bit         OddParity = (PARITY == 2);
   localparam logic [3:0] LastData  = 4'(DATA_BITS - 1);
   localparam logic [3:0] LastStop  = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 en_q, en_d;

   // Next-state and next-output decode; tx_d is the line level for the next bit.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (tx_start) begin
               state_d = StSync;
               shreg_d = tx_data;
               par_d   = (^tx_data) ^ OddParity;
               busy_d  = 1'b1;
            end
         end
         // Wait for the bit grid so the start bit lasts a full tick period.
         StSync: begin
            if (baud_tick) begin
               state_d = StStart;
               tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (baud_tick) begin
               state_d = StData;
               cnt_d   = '0;
               tx_d    = shreg_q[0];
            end
         end
         StData: begin
            if (baud_tick) begin
               shreg_d = shreg_q >> 1;
               if (cnt_q == LastData) begin
                  cnt_d = '0;
                  if (HasParity) begin
                     state_d = StParity;
                     tx_d    = par_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
                  tx_d  = shreg_q[1];
               end
            end
         end
         StParity: begin
            if (baud_tick) begin
               state_d = StStop;
               cnt_d   = '0;
               tx_d    = 1'b1;
            end
         end
         StStop: begin
            if (baud_tick) begin
               if (cnt_q == LastStop) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
      en_d = (state_d != StIdle);
   end

   // State and registered outputs; reset forces the line idle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         en_q    <= en_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;
   assign baud_en = en_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations (8N1, 8E2, 7O1) share
// clock, reset and a free-running 16-clk baud tick. Accepted words go into a
// scoreboard queue; per-DUT monitors sample the line at each tick and compare
// whole frames against a frame built from the word with plain arithmetic.
module tb_uart_tx_serializer;

   localparam int DB [3] = '{8, 8, 7};
   localparam int PAR[3] = '{0, 1, 2};
   localparam int SB [3] = '{1, 2, 1};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic [3:0] tick_cnt = 4'd0;
   logic [2:0] start_v;
   logic [7:0] data_v [3];
   logic [2:0] tx_w, busy_w, done_w, en_w;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt [3] = '{0, 0, 0};
   int frames   [3] = '{0, 0, 0};

   typedef struct packed {
      logic [1:0] g;
      logic [7:0] d;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   // Baud generator stand-in: one-clk pulse every 16 clocks.
   always @(posedge clk) tick_cnt <= tick_cnt + 4'd1;
   assign baud_tick = (tick_cnt == 4'd15);

   uart_tx_serializer #(.DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0])) u_dut0 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_start(start_v[0]),
      .tx_data(data_v[0]), .baud_en(en_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
      .tx_done(done_w[0])
   );
   uart_tx_serializer #(.DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1])) u_dut1 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_start(start_v[1]),
      .tx_data(data_v[1]), .baud_en(en_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
      .tx_done(done_w[1])
   );
   uart_tx_serializer #(.DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2])) u_dut2 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_start(start_v[2]),
      .tx_data(data_v[2][6:0]), .baud_en(en_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]),
      .tx_done(done_w[2])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int flen(input int g);
      return 1 + DB[g] + ((PAR[g] == 1 || PAR[g] == 2) ? 1 : 0) + SB[g];
   endfunction

   // Reference frame, bit 0 first on the line.
   function automatic logic [15:0] exp_frame(input int g, input logic [7:0] d);
      logic [15:0] f;
      int n;
      int ones;
      f    = '0;
      n    = 1;
      ones = 0;
      for (int i = 0; i < DB[g]; i++) begin
         f[n] = d[i];
         ones += int'(d[i]);
         n++;
      end
      if (PAR[g] == 1) begin
         f[n] = (ones % 2) != 0;
         n++;
      end else if (PAR[g] == 2) begin
         f[n] = (ones % 2) == 0;
         n++;
      end
      for (int i = 0; i < SB[g]; i++) begin
         f[n] = 1'b1;
         n++;
      end
      return f;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_mon
      int          pos;
      logic [15:0] got, expf;
      logic        end_pend, prev_tx, prev_tick;
      exp_t        e;
      // Frame monitor: line sampled at the end of each bit period.
      always @(negedge clk) begin
         if (!rst_n) begin
            pos       = 0;
            end_pend  = 1'b0;
            prev_tx   = 1'b1;
            prev_tick = 1'b0;
         end else begin
            if (done_w[g]) done_cnt[g]++;
            if (tx_w[g] !== prev_tx) check($sformatf("dut%0d_edge_on_tick", g), 32'(prev_tick), 1);
            if (end_pend) begin
               check($sformatf("dut%0d_end_busy_done_en", g),
                     {29'd0, busy_w[g], done_w[g], en_w[g]}, 32'b010);
               end_pend = 1'b0;
            end
            if (baud_tick) begin
               if (pos == 0) begin
                  if (tx_w[g] == 1'b0) begin
                     if (sb_q.size() == 0 || int'(sb_q[0].g) != g) begin
                        check($sformatf("dut%0d_unexpected_frame", g), 1, 0);
                        expf = '1;
                     end else begin
                        e    = sb_q.pop_front();
                        expf = exp_frame(g, e.d);
                     end
                     got = '0;
                     pos = 1;
                  end
               end else begin
                  got[pos] = tx_w[g];
                  pos++;
                  if (pos == flen(g)) begin
                     check($sformatf("dut%0d_frame", g), 32'(got), 32'(expf));
                     frames[g]++;
                     pos      = 0;
                     end_pend = 1'b1;
                  end
               end
            end
            prev_tx   = tx_w[g];
            prev_tick = baud_tick;
         end
      end
   end

   // Call at a negedge with the DUT idle; accept happens on the next posedge.
   task automatic send(input int g, input logic [7:0] d);
      exp_t e;
      start_v[g] = 1'b1;
      data_v[g]  = d;
      e.g = 2'(g);
      e.d = d;
      sb_q.push_back(e);
      @(negedge clk);
      start_v[g] = 1'b0;
      data_v[g]  = 8'($urandom);
      check($sformatf("dut%0d_accept_busy_en", g), {30'd0, busy_w[g], en_w[g]}, 32'b11);
   endtask

   task automatic wait_idle(input int g);
      int n = 0;
      while (busy_w[g] && n < 600) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("dut%0d_idle_in_time", g), 32'(busy_w[g]), 0);
   endtask

   task automatic wait_tx_low(input int g);
      int n = 0;
      while (tx_w[g] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("dut%0d_start_seen", g), 32'(tx_w[g]), 0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dc;
      rst_n   = 1'b0;
      start_v = '0;
      for (int g = 0; g < 3; g++) data_v[g] = 8'h00;
      repeat (5) @(negedge clk);
      for (int g = 0; g < 3; g++)
         check($sformatf("dut%0d_reset_tx_busy_done_en", g),
               {28'd0, tx_w[g], busy_w[g], done_w[g], en_w[g]}, 32'b1000);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check($sformatf("dut%0d_idle_tx_busy_en", g),
               {29'd0, tx_w[g], busy_w[g], en_w[g]}, 32'b100);
         check($sformatf("dut%0d_idle_no_done", g), 32'(done_cnt[g]), 0);
      end

      // Basic 8N1 with start alignment and frame length.
      send(0, 8'h55);
      n = 0;
      while (!baud_tick && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("basic_sync_tx_high", 32'(tx_w[0]), 1);
      @(negedge clk);
      check("basic_start_on_first_tick", 32'(tx_w[0]), 0);
      n = 0;
      while (!done_w[0] && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("basic_start_to_done_clks", 32'(n), 160);
      wait_idle(0);

      // Parity cases.
      send(1, 8'h07);
      wait_idle(1);
      send(2, 8'h07);
      wait_idle(2);
      send(1, 8'h00);
      wait_idle(1);

      // Busy rejection and data stability.
      send(0, 8'hA3);
      wait_tx_low(0);
      repeat (40) @(negedge clk);
      start_v[0] = 1'b1;
      data_v[0]  = 8'hFF;
      @(negedge clk);
      data_v[0]  = 8'h5A;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_idle(0);
      repeat (60) @(negedge clk);
      check("reject_no_second_frame", {30'd0, busy_w[0], tx_w[0]}, 32'b01);

      // Back-to-back with tx_start held high, two stop bits.
      start_v[1] = 1'b1;
      data_v[1]  = 8'h81;
      sb_q.push_back('{g: 2'd1, d: 8'h81});
      @(negedge clk);
      data_v[1] = 8'h3C;
      sb_q.push_back('{g: 2'd1, d: 8'h3C});
      n = 0;
      while (!done_w[1] && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done", 32'(done_w[1]), 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("b2b_reaccept_busy", 32'(busy_w[1]), 1);
            start_v[1] = 1'b0;
         end
      end while (tx_w[1] && n < 40);
      check("b2b_done_to_start_clks", 32'(n), 16);
      wait_idle(1);

      // Reset in the middle of data bit 3.
      send(0, 8'hF0);
      wait_tx_low(0);
      repeat (16 + 48 + 5) @(negedge clk);
      dc = done_cnt[0];
      #2 rst_n = 1'b0;
      #1;
      check("midreset_tx_busy", {30'd0, tx_w[0], busy_w[0]}, 32'b10);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check("midreset_no_done", 32'(done_cnt[0]), 32'(dc));
      send(0, 8'h12);
      wait_idle(0);

      // Randomized traffic on every configuration.
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send(g, 8'($urandom));
            wait_idle(g);
         end
      end

      repeat (40) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 0);
      for (int g = 0; g < 3; g++)
         check($sformatf("dut%0d_done_count", g), 32'(done_cnt[g]), 32'(frames[g]));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Serializes parallel bytes onto the RS232 TX line. It sits directly downstream of the baud tick generator: its baud_en output drives the generator's enable, and it consumes the generator's tick output. It frames each word as start bit, data bits LSB-first, optional parity, then stop bit(s). It presents a single-word start/busy handshake to the processor-side I/O logic.

Parameters:
DATA_BITS, 8, data bits per frame; legal values 5 to 8.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock (50 MHz in the target design)
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk-wide pulse per bit period, from the baud generator
tx_start  input  1  request to send tx_data; sampled only in IDLE
tx_data  input  DATA_BITS  word to send; captured on accept
baud_en  output  1  enable for the baud generator; high whenever state != IDLE
tx  output  1  serial line; idle high
tx_busy  output  1  high from the cycle after accept until frame end
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0: state = IDLE, tx = 1, tx_busy = 0, tx_done = 0, baud_en = 0, shift register = 0, bit counter = 0.
- All outputs are registered. No combinational path exists from any input to any output.
- Accept condition: state == IDLE and tx_start == 1 at a rising clk edge.
  - On accept, tx_data is latched into the shift register and the parity bit is computed from the latched data (XOR reduction; inverted for odd parity).
  - On accept, state moves to SYNC, tx_busy goes to 1 and baud_en goes to 1.
- tx_start outside IDLE is ignored; the latched word is unaffected. tx_data changes after accept have no effect.
- State machine (advances only on a clk edge with baud_tick == 1, except IDLE -> SYNC):
  - IDLE: tx = 1. Go to SYNC on accept.
  - SYNC: tx = 1. Go to START on the first baud_tick. This aligns the start bit to the bit grid, so the start bit lasts exactly one tick period.
  - START: tx = 0. Go to DATA on baud_tick, with bit counter = 0.
  - DATA: tx = shift register LSB. On each tick, shift right and increment the counter. After DATA_BITS ticks, go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: tx = parity bit. Go to STOP on tick.
  - STOP: tx = 1. After STOP_BITS ticks, go to IDLE. On that same edge tx_done = 1 for one cycle and tx_busy goes to 0.
- Latency:
  - Accept to tx low: 1 + (cycles until next tick) clk cycles.
  - Each bit lasts exactly one tick period.
  - Frame length is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS tick periods, measured from the SYNC -> START tick.
- Back-to-back: a tx_start asserted in the cycle tx_done is high is accepted, because state is already IDLE. Inter-frame gap is then SYNC only (at least 1 clk, at most 1 tick period).
- baud_tick arriving in IDLE is ignored.
- baud_tick held high for consecutive cycles (illegal) advances one bit per cycle; no protection is provided.
- Reset asserted mid-frame aborts immediately: tx returns to 1 asynchronously and no tx_done is produced.
- Unused PARITY encoding 3 is treated as none.

Test Plan:
- Reset and idle: hold rst_n = 0 for 5 cycles, release, no tx_start for 50 cycles -> tx = 1, tx_busy = 0, baud_en = 0, tx_done never pulses.
- Basic 8N1 frame: bench drives baud_tick every 16 clk; tx_start pulse with tx_data = 0x55 -> baud_en = 1 next cycle; tx low at the first tick after accept; line sequence 0,1,0,1,0,1,0,1,0,1 with each bit 16 clk; tx_done pulses once 160 clk after the start-bit edge; tx_busy drops on the same edge.
- Parity: PARITY = 1 with tx_data = 0x07 -> parity bit 1; PARITY = 2 with 0x07 -> parity bit 0; PARITY = 1 with 0x00 -> parity bit 0; frame is 11 bits.
- Busy rejection and data stability: send 0xA3, then mid-DATA assert tx_start with tx_data = 0xFF and change tx_data -> transmitted bits still encode 0xA3 (1,1,0,0,0,1,0,1); no second frame follows.
- Back-to-back with two stop bits: STOP_BITS = 2; hold tx_start high continuously with 0x81 then 0x3C -> two complete frames, each with a 2-tick stop period; second start bit begins at the first tick after the tx_done cycle.
- Reset mid-frame: assert rst_n = 0 during DATA bit 3 of 0xF0 -> tx = 1 within the same cycle; tx_busy = 0; no tx_done. After release, a new frame with 0x12 transmits correctly.
